// File: rtl/ntt_addr_gen.sv
// ntt_addr_gen: per-lane port-A address, olen and zeta index sequencer for the 8-BU 256-point NTT/INTT.
// Latency: outputs are registered; start at edge T gives the first valid butterfly at edge T+1.
// Backpressure: none by default; with ADDR_GEN_STALL_EN, stall_i freezes RUN/GAP counters and all outputs.
module ntt_addr_gen #(
    parameter int ADDR_WIDTH = 8,
    parameter int ADDR_ZETA  = 7,
    parameter int GAP_CYCLES = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_decode,
    input  logic                      is_NTT,
`ifdef ADDR_GEN_STALL_EN
    input  logic                      stall_i,
`endif
    output logic [8*ADDR_WIDTH-1:0]   addr_core_o,
    output logic [7:0]                olen,
    output logic [8*ADDR_ZETA-1:0]    addr_zeta_o,
    output logic                      valid_o,
    output logic [2:0]                layer_o,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam int         LANES      = 8;
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_RUN      = 2'd1;
    localparam logic [1:0] S_GAP      = 2'd2;
    localparam logic [1:0] S_DONE     = 2'd3;
    localparam logic [2:0] LAST_LAYER = 3'd6;
    localparam logic [3:0] GAP_LAST   = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    logic [1:0] state;
    logic       mode;
    logic [2:0] layer;
    logic [3:0] cnt;
    logic [3:0] gap_cnt;
    logic       hold;

    logic [2:0] shift_s;
    logic [7:0] len_c;
    logic [6:0] lane_mask;
    logic [6:0] lane_b;
    logic [6:0] lane_g;
    logic [7:0] lane_addr;
    logic [7:0] lane_zeta;
    logic [8*ADDR_WIDTH-1:0] addr_nxt;
    logic [8*ADDR_ZETA-1:0]  zeta_nxt;

`ifdef ADDR_GEN_STALL_EN
    assign hold = stall_i && ((state == S_RUN) || (state == S_GAP));
`else
    assign hold = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= S_IDLE;
            mode    <= 1'b0;
            layer   <= 3'd0;
            cnt     <= 4'd0;
            gap_cnt <= 4'd0;
        end else if (!hold) begin
            case (state)
                S_IDLE: begin
                    if (start_decode) begin
                        state <= S_RUN;
                        mode  <= is_NTT;
                        layer <= 3'd0;
                        cnt   <= 4'd0;
                    end
                end
                S_RUN: begin
                    // cnt wraps 15 -> 0, which is exactly the next layer's first cycle
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        if (layer == LAST_LAYER) begin
                            state <= S_DONE;
                        end else if (GAP_CYCLES > 0) begin
                            state   <= S_GAP;
                            gap_cnt <= GAP_LAST;
                        end else begin
                            layer <= layer + 3'd1;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == 4'd0) begin
                        state <= S_RUN;
                        layer <= layer + 3'd1;
                        cnt   <= 4'd0;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // len is a power of two, so addr is b with a zero bit inserted at position log2(len)
    always_comb begin
        shift_s   = mode ? (3'd7 - layer) : (layer + 3'd1);
        len_c     = 8'd1 << shift_s;
        lane_mask = 7'(len_c - 8'd1);
        lane_b    = '0;
        lane_g    = '0;
        lane_addr = '0;
        lane_zeta = '0;
        addr_nxt  = '0;
        zeta_nxt  = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_b    = {3'(i), cnt};
            lane_g    = lane_b >> shift_s;
            lane_addr = {lane_b & ~lane_mask, 1'b0} | {1'b0, lane_b & lane_mask};
            lane_zeta = mode ? ((8'd1 << layer) + {1'b0, lane_g})
                             : ((8'd128 >> layer) - 8'd1 - {1'b0, lane_g});
            addr_nxt[i*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(lane_addr);
            zeta_nxt[i*ADDR_ZETA  +: ADDR_ZETA]  = ADDR_ZETA'(lane_zeta);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            addr_core_o <= '0;
            addr_zeta_o <= '0;
            olen        <= 8'd0;
            valid_o     <= 1'b0;
            layer_o     <= 3'd0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else if (!hold) begin
            valid_o <= (state == S_RUN);
            busy_o  <= (state != S_IDLE);
            done_o  <= (state == S_DONE);
            layer_o <= layer;
            if (state == S_RUN) begin
                addr_core_o <= addr_nxt;
                addr_zeta_o <= zeta_nxt;
                olen        <= len_c;
            end
        end
    end

endmodule

// File: tb/tb_ntt_addr_gen.sv
// Scoreboard bench for ntt_addr_gen: full NTT/INTT runs, issue timing, mid-run reset and optional stall.
module tb_ntt_addr_gen;

    localparam int GAP        = 4;
    localparam int LAST_VALID = 112 + 6*GAP;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_decode;
    logic        is_NTT;
    logic        stall;
    logic [63:0] addr_core_o;
    logic [7:0]  olen;
    logic [55:0] addr_zeta_o;
    logic        valid_o;
    logic [2:0]  layer_o;
    logic        busy_o;
    logic        done_o;

    always #5 clk_i = ~clk_i;

    ntt_addr_gen #(.ADDR_WIDTH(8), .ADDR_ZETA(7), .GAP_CYCLES(GAP)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_decode (start_decode),
        .is_NTT       (is_NTT),
`ifdef ADDR_GEN_STALL_EN
        .stall_i      (stall),
`endif
        .addr_core_o  (addr_core_o),
        .olen         (olen),
        .addr_zeta_o  (addr_zeta_o),
        .valid_o      (valid_o),
        .layer_o      (layer_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    typedef struct {
        bit          ntt;
        int          l;
        int          c;
        logic [63:0] addr;
        logic [55:0] zeta;
        logic [7:0]  olen;
    } beat_t;

    beat_t sb[$];
    beat_t mon_e;
    int    n_chk  = 0;
    int    n_fail = 0;
    logic  stalled_edge = 1'b0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int m_len(input bit ntt, input int l);
        return ntt ? (128 >> l) : (2 << l);
    endfunction

    function automatic logic [63:0] m_addr(input bit ntt, input int l, input int c);
        logic [63:0] r;
        int len, b, g, o;
        r   = '0;
        len = m_len(ntt, l);
        for (int i = 0; i < 8; i++) begin
            b = 16*i + c;
            g = b / len;
            o = b % len;
            r[8*i +: 8] = 8'(2*len*g + o);
        end
        return r;
    endfunction

    function automatic logic [55:0] m_zeta(input bit ntt, input int l, input int c);
        logic [55:0] r;
        int len, b, g, z;
        r   = '0;
        len = m_len(ntt, l);
        for (int i = 0; i < 8; i++) begin
            b = 16*i + c;
            g = b / len;
            z = ntt ? (128/len + g) : (256/len - 1 - g);
            r[7*i +: 7] = 7'(z);
        end
        return r;
    endfunction

    task automatic push_run(input bit ntt);
        beat_t e;
        for (int l = 0; l < 7; l++) begin
            for (int c = 0; c < 16; c++) begin
                e.ntt  = ntt;
                e.l    = l;
                e.c    = c;
                e.addr = m_addr(ntt, l, c);
                e.zeta = m_zeta(ntt, l, c);
                e.olen = 8'(m_len(ntt, l));
                sb.push_back(e);
            end
        end
    endtask

    always @(posedge clk_i) stalled_edge <= stall;

    always @(negedge clk_i) begin
        if (rst_i === 1'b1 && valid_o === 1'b1 && !stalled_edge) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", 64'(valid_o), 64'(0));
            end else begin
                mon_e = sb.pop_front();
                chk("beat_addr",  addr_core_o,        mon_e.addr);
                chk("beat_zeta",  64'(addr_zeta_o),   64'(mon_e.zeta));
                chk("beat_olen",  64'(olen),          64'(mon_e.olen));
                chk("beat_layer", 64'(layer_o),       64'(mon_e.l));
                if (mon_e.ntt && mon_e.l == 0 && (mon_e.c == 0 || mon_e.c == 5)) begin
                    chk("f_l0_olen", 64'(olen), 64'(128));
                    for (int i = 0; i < 8; i++) begin
                        chk("f_l0_addr", 64'(addr_core_o[8*i +: 8]), 64'(16*i + mon_e.c));
                        chk("f_l0_zeta", 64'(addr_zeta_o[7*i +: 7]), 64'(1));
                    end
                end
                if (mon_e.ntt && mon_e.l == 6 && mon_e.c == 15) begin
                    chk("f_l6_olen",  64'(olen), 64'(2));
                    chk("f_l6_addr7", 64'(addr_core_o[63:56]), 64'(253));
                    chk("f_l6_zeta7", 64'(addr_zeta_o[55:49]), 64'(127));
                    chk("f_l6_addr0", 64'(addr_core_o[7:0]),   64'(29));
                    chk("f_l6_zeta0", 64'(addr_zeta_o[6:0]),   64'(71));
                end
                if (!mon_e.ntt && mon_e.l == 0 && mon_e.c == 0) begin
                    chk("i_l0c0_addr0", 64'(addr_core_o[7:0]), 64'(0));
                    chk("i_l0c0_zeta0", 64'(addr_zeta_o[6:0]), 64'(127));
                end
                if (!mon_e.ntt && mon_e.l == 0 && mon_e.c == 15) begin
                    chk("i_l0c15_addr7", 64'(addr_core_o[63:56]), 64'(253));
                    chk("i_l0c15_zeta7", 64'(addr_zeta_o[55:49]), 64'(64));
                end
                if (!mon_e.ntt && mon_e.l == 6 && mon_e.c == 0) begin
                    chk("i_l6_olen", 64'(olen), 64'(128));
                    for (int i = 0; i < 8; i++)
                        chk("i_l6_zeta", 64'(addr_zeta_o[7*i +: 7]), 64'(1));
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_addr"},  addr_core_o,      64'(0));
        chk({tag, "_zeta"},  64'(addr_zeta_o), 64'(0));
        chk({tag, "_olen"},  64'(olen),        64'(0));
        chk({tag, "_valid"}, 64'(valid_o),     64'(0));
        chk({tag, "_layer"}, 64'(layer_o),     64'(0));
        chk({tag, "_busy"},  64'(busy_o),      64'(0));
        chk({tag, "_done"},  64'(done_o),      64'(0));
    endtask

    task automatic run_transform(input bit ntt, input bit inject);
        bit exp_v;
        start_decode = 1'b1;
        is_NTT       = ntt;
        push_run(ntt);
        @(negedge clk_i);
        start_decode = 1'b0;
        for (int k = 0; k <= LAST_VALID + 4; k++) begin
            if (k > 0) @(negedge clk_i);
            exp_v = (k >= 1) && (k <= LAST_VALID) && (((k - 1) % (16 + GAP)) < 16);
            chk("valid_o", 64'(valid_o), 64'(exp_v));
            chk("done_o",  64'(done_o),  64'(k == LAST_VALID + 1));
            chk("busy_o",  64'(busy_o),  64'((k >= 1) && (k <= LAST_VALID + 1)));
            if (inject && k == 49) begin
                start_decode = 1'b1;
                is_NTT       = ~ntt;
            end
            if (inject && k == 50) begin
                start_decode = 1'b0;
                is_NTT       = ntt;
            end
        end
        chk("sb_empty", 64'(sb.size()), 64'(0));
    endtask

    task automatic run_abort();
        start_decode = 1'b1;
        is_NTT       = 1'b1;
        push_run(1'b1);
        @(negedge clk_i);
        start_decode = 1'b0;
        repeat (39) @(negedge clk_i);
        @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        check_all_zero("abort");
        sb.delete();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_i);
            chk("abort_no_done", 64'(done_o), 64'(0));
        end
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("abort_idle_busy", 64'(busy_o), 64'(0));
    endtask

`ifdef ADDR_GEN_STALL_EN
    task automatic run_stall();
        start_decode = 1'b1;
        is_NTT       = 1'b1;
        push_run(1'b1);
        @(negedge clk_i);
        start_decode = 1'b0;
        for (int k = 0; k <= LAST_VALID + 6; k++) begin
            if (k > 0) @(negedge clk_i);
            if (k == 48) begin
                chk("stall_pre_addr", addr_core_o, m_addr(1'b1, 2, 7));
                stall = 1'b1;
            end
            if (k >= 49 && k <= 51) begin
                chk("stall_hold_valid", 64'(valid_o), 64'(1));
                chk("stall_hold_addr",  addr_core_o, m_addr(1'b1, 2, 7));
                chk("stall_hold_zeta",  64'(addr_zeta_o), 64'(m_zeta(1'b1, 2, 7)));
            end
            if (k == 51) stall = 1'b0;
            if (k == 52) chk("stall_resume_addr", addr_core_o, m_addr(1'b1, 2, 8));
            chk("stall_done", 64'(done_o), 64'(k == LAST_VALID + 4));
        end
        chk("stall_sb_empty", 64'(sb.size()), 64'(0));
    endtask
`endif

    initial begin
        rst_i        = 1'b0;
        start_decode = 1'b0;
        is_NTT       = 1'b0;
        stall        = 1'b0;
        repeat (3) @(negedge clk_i);
        check_all_zero("reset");
        rst_i = 1'b1;
        @(negedge clk_i);
        run_transform(1'b1, 1'b1);
        run_transform(1'b0, 1'b0);
        run_abort();
        run_transform(1'b0, 1'b0);
`ifdef ADDR_GEN_STALL_EN
        run_stall();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
